counter_b4_arbiter: RTL
=======================

Name: counter_b4_arbiter

Overview:
- Shares one 4-bit mode counter (counter_b4) between two requesters.
- Each request is a job: {mode, D, run length}.
- The arbiter grants jobs round-robin and drives the counter's enable/mode/D for the job length.
- After the job it samples the counter Q and returns it with a single-cycle completion pulse.

Parameters:
- LEN_W, 4, width of the run-length field per request.

Ports:
- b4_clk  in  1  clock; all logic on rising edge
- b4_reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_mode  in  2  job mode: 00 +3, 01 -1, 10 +1, 11 load D
- req0_d  in  4  parallel-load value (used when mode=11)
- req0_len  in  LEN_W  enabled-cycle count; 0 treated as 1
- req0_ready  out  1  job accepted when valid&ready
- req1_valid / req1_mode / req1_d / req1_len / req1_ready  same as requester 0
- ctr_enable  out  1  to counter enable
- ctr_mode  out  2  to counter mode
- ctr_D  out  4  to counter D
- ctr_Q  in  4  counter value (registered, 1-cycle latency)
- ctr_rco  in  1  counter ripple-carry out
- busy  out  1  high in any state except IDLE
- done_valid  out  1  one-cycle completion pulse; no backpressure
- done_id  out  1  requester that owned the finished job
- done_q  out  4  ctr_Q sampled at job end

Behaviour:
- Reset values: ctr_enable=0, ctr_mode=00, ctr_D=0, done_valid=0, done_id=0, done_q=0, busy=0, state=IDLE, last_grant=1 (requester 0 wins first tie).
- Reset mid-job: the job is abandoned, all state and outputs return to reset values, and no done pulse is issued.
- FSM states and transitions:
  - IDLE -> RUN on accept.
  - RUN -> DRAIN when run_cnt==1.
  - DRAIN -> DONE.
  - DONE -> IDLE.
- IDLE arbitration:
  - winner = sole valid requester.
  - If both are valid, winner = requester != last_grant.
  - reqN_ready is combinational and equals (state==IDLE && winner==N). Both readys are never high together.
- Accept (cycle T):
  - Latch mode, d, and id, and update last_grant.
  - run_cnt = max(len,1); mode 11 forces run_cnt=1.
- RUN (T+1 .. T+L):
  - ctr_enable=1, ctr_mode and ctr_D are the latched values.
  - run_cnt decrements each cycle.
- DRAIN (T+L+1): ctr_enable=0, done_q <= ctr_Q.
- DONE (T+L+2): done_valid=1 and done_id=latched id. A new job can be accepted at T+L+3.
- Outside RUN, ctr_enable=0 while ctr_mode and ctr_D hold their last values.
- run_cnt is LEN_W bits wide; len=0 follows the same path as len=1.
- A requester dropping valid is only observed in IDLE. Request inputs are ignored outside the accept cycle.

Optional Feature:
- Macro CTR_ARB_WRAP_CNT_EN.
- Defined:
  - Adds output done_wraps [3:0], a saturating count (max 15) of RUN cycles with ctr_rco=1 for the current job.
  - The count is cleared on accept, presented with done_valid, and reset to 0.
- Undefined: the port and its logic are absent, and ctr_rco is unused.

Decomposition:
- Package counter_b4_pkg:
  - Mode constants MODE_ADD3=2'b00, MODE_DEC=2'b01, MODE_INC=2'b10, MODE_LOAD=2'b11.
  - FSM state encoding IDLE/RUN/DRAIN/DONE.
- Sub-module counter_b4_rr_pick:
  - Pure 2-way round-robin winner selection.
  - Inputs: valid[1:0], last_grant. Outputs: winner, any_valid.

Test Plan:
- req0 mode=11 d=5 accepted at T, no other traffic -> ctr_enable high at T+1 only; done_valid=1 at T+3 with done_id=0, done_q=5.
- Following job req0 mode=10 len=3 (counter at 5) -> ctr_enable high for 3 cycles; done_q=8 at T+5.
- req0 and req1 both valid continuously, each with len=1 -> grants alternate 0,1,0,1; done_id alternates; each job occupies 4 cycles.
- len=0, mode=01 starting from Q=8 -> exactly one enabled cycle; done_q=7.
- b4_reset asserted during RUN of a len=10 job -> next cycle all outputs are at reset values with no done pulse; req0 wins the next accept.
- With CTR_ARB_WRAP_CNT_EN: Q=13, mode=00, len=2 -> rco observed during RUN; done_wraps>=1, matching a reference-model count of rco cycles.

Source files
------------

// File: rtl/counter_b4_pkg.sv
// -----------------------------------------------------------------------------
// counter_b4_pkg
// Shared definitions for the counter_b4 job arbiter:
//   - counter_b4 mode encodings (what the shared counter does when enabled)
//   - arbiter FSM state encoding
//   - saturation limit for the optional wrap counter
// No ports; imported by counter_b4_rr_pick and counter_b4_arbiter.
// -----------------------------------------------------------------------------
package counter_b4_pkg;

    // counter_b4 mode field
    localparam logic [1:0] MODE_ADD3 = 2'b00;  // Q <= Q + 3
    localparam logic [1:0] MODE_DEC  = 2'b01;  // Q <= Q - 1
    localparam logic [1:0] MODE_INC  = 2'b10;  // Q <= Q + 1
    localparam logic [1:0] MODE_LOAD = 2'b11;  // Q <= D

    // Arbiter job sequencing
    typedef enum logic [1:0] {
        IDLE  = 2'b00,  // waiting for a request
        RUN   = 2'b01,  // counter enabled for the job length
        DRAIN = 2'b10,  // counter settled, capture Q
        DONE  = 2'b11   // completion pulse
    } state_e;

    // Largest value the 4-bit wrap counter holds before saturating
    localparam logic [3:0] WRAP_MAX = 4'hF;

endpackage : counter_b4_pkg

// File: rtl/counter_b4_rr_pick.sv
// -----------------------------------------------------------------------------
// counter_b4_rr_pick
// Pure combinational 2-way round-robin winner selection.
//   valid[1:0]  in   request valid per requester
//   last_grant  in   requester granted most recently
//   winner      out  selected requester (only meaningful when any_valid)
//   any_valid   out  at least one requester is valid
// A sole valid requester always wins; on a tie the requester that was not
// granted last time wins.
// -----------------------------------------------------------------------------
module counter_b4_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_valid
);

    always_comb begin
        // NOTE: every always_comb output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        winner = 1'b0;
        case (valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    assign any_valid = |valid;

endmodule : counter_b4_rr_pick

// File: rtl/counter_b4_arbiter.sv
// -----------------------------------------------------------------------------
// counter_b4_arbiter
// Shares one 4-bit mode counter (counter_b4) between two requesters. Each
// request is a job {mode, d, len}; jobs are granted round-robin, the counter
// is enabled for the job length, and the settled counter value is returned
// with a one-cycle completion pulse.
//
// Ports (clock b4_clk rising edge, synchronous active-high reset b4_reset):
//   reqN_valid/mode/d/len  in   job request from requester N (N = 0, 1)
//   reqN_ready             out  job accepted on valid & ready (IDLE only)
//   ctr_enable/mode/D      out  drive the shared counter
//   ctr_Q, ctr_rco         in   counter value (1-cycle latency) and carry out
//   busy                   out  arbiter is not IDLE
//   done_valid/id/q        out  completion pulse, owner, captured counter value
//   done_wraps             out  (only with CTR_ARB_WRAP_CNT_EN) saturating
//                               count of RUN cycles that saw ctr_rco
//
// Build option: define CTR_ARB_WRAP_CNT_EN to add done_wraps.
//
// Job timeline for an accept in cycle T with effective length L:
//   T+1..T+L RUN (counter enabled), T+L+1 DRAIN (capture Q),
//   T+L+2 DONE (pulse), next accept possible at T+L+3.
// -----------------------------------------------------------------------------
module counter_b4_arbiter
    import counter_b4_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             b4_clk,
    input  logic             b4_reset,

    input  logic             req0_valid,
    input  logic [1:0]       req0_mode,
    input  logic [3:0]       req0_d,
    input  logic [LEN_W-1:0] req0_len,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [1:0]       req1_mode,
    input  logic [3:0]       req1_d,
    input  logic [LEN_W-1:0] req1_len,
    output logic             req1_ready,

    output logic             ctr_enable,
    output logic [1:0]       ctr_mode,
    output logic [3:0]       ctr_D,
    input  logic [3:0]       ctr_Q,
    input  logic             ctr_rco,

    output logic             busy,
    output logic             done_valid,
    output logic             done_id,
    output logic [3:0]       done_q
`ifdef CTR_ARB_WRAP_CNT_EN
   ,output logic [3:0]       done_wraps
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q,         id_d;
    logic [1:0]       mode_q,       mode_d;
    logic [3:0]       d_q,          d_d;
    logic [LEN_W-1:0] run_cnt_q,    run_cnt_d;
    logic [3:0]       q_snap_q,     q_snap_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             winner;
    logic             any_valid;
    logic             idle;
    logic             accept;

    counter_b4_rr_pick u_rr_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign idle       = (state_q == IDLE);
    assign accept     = idle && any_valid;
    assign req0_ready = accept && !winner;
    assign req1_ready = accept &&  winner;

    // Fields of the winning request, used only on the accept cycle
    logic [1:0]       sel_mode;
    logic [3:0]       sel_d;
    logic [LEN_W-1:0] sel_len;

    assign sel_mode = winner ? req1_mode : req0_mode;
    assign sel_d    = winner ? req1_d    : req0_d;
    assign sel_len  = winner ? req1_len  : req0_len;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        mode_d       = mode_q;
        d_d          = d_q;
        run_cnt_d    = run_cnt_q;
        q_snap_d     = q_snap_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = RUN;
                    last_grant_d = winner;
                    id_d         = winner;
                    mode_d       = sel_mode;
                    d_d          = sel_d;
                    // A load only needs one enabled cycle; len 0 runs as 1
                    if (sel_mode == MODE_LOAD || sel_len == '0) begin
                        run_cnt_d = LEN_W'(1);
                    end else begin
                        run_cnt_d = sel_len;
                    end
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q - LEN_W'(1);
                if (run_cnt_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // ctr_Q now reflects the last enabled cycle
                q_snap_d = ctr_Q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge b4_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (b4_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;  // requester 0 wins the first tie
            id_q         <= 1'b0;
            mode_q       <= MODE_ADD3;
            d_q          <= '0;
            run_cnt_q    <= '0;
            q_snap_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            mode_q       <= mode_d;
            d_q          <= d_d;
            run_cnt_q    <= run_cnt_d;
            q_snap_q     <= q_snap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: mode/D hold the last job's values when not running
    // ------------------------------------------------------------------
    assign ctr_enable = (state_q == RUN);
    assign ctr_mode   = mode_q;
    assign ctr_D      = d_q;
    assign busy       = !idle;
    assign done_valid = (state_q == DONE);
    assign done_id    = id_q;
    assign done_q     = q_snap_q;

`ifdef CTR_ARB_WRAP_CNT_EN
    // ------------------------------------------------------------------
    // Wrap counter: RUN cycles with ctr_rco, saturating, per job
    // ------------------------------------------------------------------
    logic [3:0] wraps_q, wraps_d;

    always_comb begin
        wraps_d = wraps_q;
        if (accept) begin
            wraps_d = '0;
        end else if (state_q == RUN && ctr_rco && wraps_q != WRAP_MAX) begin
            wraps_d = wraps_q + 4'd1;
        end
    end

    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign done_wraps = wraps_q;
`else
    // Carry out only feeds the optional wrap counter
    logic unused_rco;
    assign unused_rco = ctr_rco;
`endif

endmodule : counter_b4_arbiter
